// File: rtl/serv_rf_ram_arbiter.sv
// Register-file SRAM arbiter: the SERV core owns the RAM during its burst windows,
// and a host/debug port slips single-word reads and writes into the idle cycles between them.
module serv_rf_ram_arbiter #(
    parameter int width       = 8,
    parameter int aw          = 8,
    parameter int CORE_WINDOW = 36
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_core_req,
    input  logic [aw-1:0]    i_core_waddr,
    input  logic [width-1:0] i_core_wdata,
    input  logic             i_core_wen,
    input  logic [aw-1:0]    i_core_raddr,
    input  logic             i_core_ren,
    output logic [width-1:0] o_core_rdata,
    output logic [aw-1:0]    o_ram_waddr,
    output logic [width-1:0] o_ram_wdata,
    output logic             o_ram_wen,
    output logic [aw-1:0]    o_ram_raddr,
    output logic             o_ram_ren,
    input  logic [width-1:0] i_ram_rdata,
    input  logic             i_host_valid,
    input  logic             i_host_we,
    input  logic [aw-1:0]    i_host_addr,
    input  logic [width-1:0] i_host_wdata,
    output logic             o_host_ready,
    output logic             o_host_rvalid,
    output logic [width-1:0] o_host_rdata,
    output logic             o_err
);
    localparam int CW = $clog2(CORE_WINDOW + 1);

    typedef enum logic [1:0] {IDLE, RCAP, RDONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    win_cnt_q, win_cnt_d;
    logic [width-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             core_en, win_idle, slot_free, host_acc;

    assign core_en   = i_core_ren | i_core_wen;
    assign win_idle  = (win_cnt_q == '0);
    assign slot_free = win_idle & ~core_en;
    // Reset masks the grant so the RAM follows the core while i_rst_n is held low.
    assign host_acc  = i_rst_n & (state_q == IDLE) & i_host_valid & slot_free;

    assign o_host_ready = host_acc;
    assign o_host_rdata = rdata_q;
    assign o_err        = err_q;
    assign o_core_rdata = i_ram_rdata;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        win_cnt_d     = win_cnt_q;
        rdata_d       = rdata_q;
        o_host_rvalid = 1'b0;
        // A core access with no open window is a contract breach; remember it until reset.
        err_d         = err_q | (core_en & win_idle);

        if (i_core_req) begin
            win_cnt_d = CW'(CORE_WINDOW);
        end else if (!win_idle) begin
            win_cnt_d = win_cnt_q - CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (host_acc && !i_host_we) state_d = RCAP;
            end
            RCAP: begin
                rdata_d = i_ram_rdata;
                state_d = RDONE;
            end
            RDONE: begin
                o_host_rvalid = i_rst_n;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ram_waddr = i_core_waddr;
        o_ram_wdata = i_core_wdata;
        o_ram_wen   = i_core_wen;
        o_ram_raddr = i_core_raddr;
        o_ram_ren   = i_core_ren;
        if (host_acc) begin
            if (i_host_we) begin
                o_ram_wen   = 1'b1;
                o_ram_waddr = i_host_addr;
                o_ram_wdata = i_host_wdata;
            end else begin
                o_ram_ren   = 1'b1;
                o_ram_raddr = i_host_addr;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments; the reset is synchronous and only acts at the edge.
        if (!i_rst_n) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

endmodule
